// File: rtl/interconnect_pkg.sv
// Shared interconnect definitions: OCP command/response encodings, the
// arbiter FSM state type, the request record and the bus widths used by the
// OCP master arbiter, its interface and its round-robin picker.
// No ports (package).
package interconnect_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    OCP_IDLE = 3'd0,
    OCP_WR   = 3'd1,
    OCP_RD   = 3'd2
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    OCP_NULL = 2'd0,
    OCP_DVA  = 2'd1,
    OCP_ERR  = 2'd3
  } ocp_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } ocp_req_t;

  // ERR (3) and the reserved code 2 both count as an error response;
  // both have bit 1 set, DVA and NULL do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/ocp_master_arbiter_if.sv
// Bundle of the two AXI-side request/response ports and the OCP master port
// served by ocp_master_arbiter.
//   master modport : the arbiter (accepts requests, drives OCP M* signals)
//   slave modport  : the environment (requesters and the OCP slave)
// Request handshake: a transaction on port N transfers on a rising edge where
// reqN_valid and reqN_ready are both high; the requester holds all reqN_*
// fields stable while valid is high and ready is low. rspN_valid is a
// single-cycle pulse with no back-pressure; rspN_rdata/rspN_err are only
// meaningful while it is high. OCP: M* are held until SCmdAccept is high, and
// SResp is a one-cycle response that is not back-pressured.
interface ocp_master_arbiter_if;
  import interconnect_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [BE_W-1:0]   req0_be;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [BE_W-1:0]   req1_be;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic [2:0]        MCmd;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MData;
  logic [BE_W-1:0]   MByteEn;
  logic              SCmdAccept;
  logic [1:0]        SResp;
  logic [DATA_W-1:0] SData;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_be,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_be,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output MCmd, MAddr, MData, MByteEn,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_be,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_be,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  MCmd, MAddr, MData, MByteEn,
    output SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker, purely combinational.
//   req[1:0]   in  : request vector
//   last_grant in  : index of the port granted most recently
//   gnt[1:0]   out : one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On contention the port that did not win last time goes next.
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ocp_master_arbiter.sv
// Shares one OCP master port between two request ports. Round-robin picks a
// port in IDLE, the latched request is presented on OCP in CMD until
// accepted, RESP waits for SResp, and the completion is pulsed back to the
// winning port one cycle later. A per-transaction counter abandons the
// transaction with an error completion after TIMEOUT-1 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response ports and OCP master signals (master modport)
//   fsm_state  : current arbiter state, for observation
module ocp_master_arbiter
  import interconnect_pkg::*;
#(
  parameter int TIMEOUT = 256  // legal range 4..65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ocp_master_arbiter_if.master  bus,
  output arb_state_e            fsm_state
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  arb_state_e        state, state_nxt;
  ocp_req_t          req_q, win_req;
  ocp_cmd_e          mcmd_q;
  logic              port_q;
  logic              last_grant;
  logic [15:0]       tmo_cnt;
  logic [1:0]        gnt;
  logic              load, done, tmo;
  logic              cpl_err;
  logic [DATA_W-1:0] cpl_rdata;
  logic [1:0]        rsp_valid_q;
  logic [1:0]        rsp_err_q;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Winner's request; reads always present every byte lane.
  always_comb begin
    win_req.write = bus.req0_write;
    win_req.addr  = bus.req0_addr;
    win_req.wdata = bus.req0_wdata;
    win_req.be    = bus.req0_be;
    if (gnt[1]) begin
      win_req.write = bus.req1_write;
      win_req.addr  = bus.req1_addr;
      win_req.wdata = bus.req1_wdata;
      win_req.be    = bus.req1_be;
    end
    if (!win_req.write) begin
      win_req.be = '1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          load      = 1'b1;
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        // Responses seen here are stray/late and deliberately ignored.
        if (tmo_cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (bus.SCmdAccept) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // A real response beats a timeout landing in the same cycle.
        if (bus.SResp != OCP_NULL) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpl_err   = done ? resp_is_err(bus.SResp) : 1'b1;
  assign cpl_rdata = (done && !cpl_err && !req_q.write) ? bus.SData : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      mcmd_q       <= OCP_IDLE;
      port_q       <= 1'b0;
      last_grant   <= 1'b1;
      tmo_cnt      <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      tmo_cnt     <= (state == ST_IDLE) ? 16'd0 : tmo_cnt + 16'd1;
      if (load) begin
        req_q  <= win_req;
        port_q <= gnt[1];
        mcmd_q <= win_req.write ? OCP_WR : OCP_RD;
      end else if (state == ST_CMD && state_nxt != ST_CMD) begin
        // Accepted or abandoned: the command drops the following cycle.
        mcmd_q <= OCP_IDLE;
      end
      if (done || tmo) begin
        rsp_valid_q[port_q] <= 1'b1;
        rsp_err_q[port_q]   <= cpl_err;
        last_grant          <= port_q;
        if (port_q) begin
          rsp1_rdata_q <= cpl_rdata;
        end else begin
          rsp0_rdata_q <= cpl_rdata;
        end
      end
    end
  end

  // rst_n gating keeps ready low while reset is held, even with valid high.
  assign bus.req0_ready = rst_n & (state == ST_IDLE) & gnt[0];
  assign bus.req1_ready = rst_n & (state == ST_IDLE) & gnt[1];

  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_err   = rsp_err_q[0];
  assign bus.rsp1_err   = rsp_err_q[1];
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;

  assign bus.MCmd    = mcmd_q;
  assign bus.MAddr   = req_q.addr;
  assign bus.MData   = req_q.wdata;
  assign bus.MByteEn = req_q.be;

  assign fsm_state = state;

endmodule

// File: tb/tb_ocp_master_arbiter.sv
// Directed bench for ocp_master_arbiter (TIMEOUT=8).
module tb_ocp_master_arbiter;
  import interconnect_pkg::*;

  localparam int CW = 71;  // {MCmd, MAddr, MData, MByteEn}
  localparam int RW = 34;  // {port, err, rdata}

  logic       clk;
  logic       rst_n = 1'b0;
  arb_state_e fsm_state;

  ocp_master_arbiter_if bus ();

  ocp_master_arbiter #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];
  logic [CW-1:0] cmd_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cmd_e(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] be);
    return {c, a, d, be};
  endfunction

  function automatic logic [RW-1:0] rsp_e(input logic p, input logic e, input logic [31:0] d);
    return {p, e, d};
  endfunction

  logic [CW-1:0] c_obs;
  logic [RW-1:0] r_obs;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.MCmd != 3'd0 && bus.SCmdAccept) begin
          c_obs = {bus.MCmd, bus.MAddr, bus.MData, bus.MByteEn};
          if (cmd_q.size() == 0) check("cmd_extra", c_obs, 0);
          else check("cmd", c_obs, cmd_q.pop_front());
        end
        if (bus.rsp0_valid || bus.rsp1_valid) begin
          if (bus.rsp0_valid && bus.rsp1_valid)
            check("rsp_both", {bus.rsp1_valid, bus.rsp0_valid}, 2'b01);
          r_obs = bus.rsp1_valid ? {1'b1, bus.rsp1_err, bus.rsp1_rdata}
                                 : {1'b0, bus.rsp0_err, bus.rsp0_rdata};
          if (exp_q.size() == 0) check("rsp_extra", r_obs, 0);
          else check("rsp", r_obs, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- OCP slave driver ----------------
  logic        auto_en = 1'b0;
  logic        auto_resp_en = 1'b1;
  logic        man_accept = 1'b0;
  logic [1:0]  man_resp = 2'd0;
  logic [31:0] man_data = '0;
  logic        resp_pending = 1'b0;
  logic [31:0] resp_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      resp_pending = auto_en && bus.MCmd != 3'd0 && bus.SCmdAccept;
      resp_data    = bus.MAddr ^ 32'hA5A5_0000;
    end
  end

  initial begin
    bus.SCmdAccept = 1'b0;
    bus.SResp      = 2'd0;
    bus.SData      = '0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_en) begin
        bus.SCmdAccept = 1'b1;
        if (resp_pending && auto_resp_en) begin
          bus.SResp = 2'd1;
          bus.SData = resp_data;
        end else begin
          bus.SResp = 2'd0;
          bus.SData = '0;
        end
      end else begin
        bus.SCmdAccept = man_accept;
        bus.SResp      = man_resp;
        bus.SData      = man_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_be = '0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_be = '0;
  endtask

  task automatic set_req(input int port, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (port == 0) begin
      bus.req0_valid = 1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_be = be;
    end else begin
      bus.req1_valid = 1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_be = be;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    auto_en = 0; auto_resp_en = 1; man_accept = 0; man_resp = 0; man_data = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // Presents one request and holds it until the handshake edge.
  task automatic issue(input int port, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    logic seen;
    seen = 1'b0;
    set_req(port, wr, a, d, be);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (port == 0) ? bus.req0_ready : bus.req1_ready;
    end
    cyc();
    if (port == 0) bus.req0_valid = 0;
    else bus.req1_valid = 0;
    check("issue_ack", seen, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || cmd_q.size() != 0); i++) cyc();
    check(tag, {exp_q.size(), cmd_q.size()}, 0);
  endtask

  // ---------------- tests ----------------
  int hs;

  initial begin
    clear_reqs();
    // Reset values, with a request pending to confirm ready stays low.
    repeat (2) cyc();
    bus.req0_valid = 1; bus.req1_valid = 1;
    @(negedge clk);
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rst_rsp", {bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_err, bus.rsp1_err}, 0);
    check("rst_rdata", {bus.rsp0_rdata, bus.rsp1_rdata}, 0);
    check("rst_ocp", {bus.MCmd, bus.MAddr, bus.MData, bus.MByteEn}, 0);
    check("rst_state", fsm_state, ST_IDLE);
    clear_reqs();
    cyc();
    rst_n = 1'b1;

    // Test 1: single read on port 0, minimum latency.
    cmd_q.push_back(cmd_e(3'd2, 32'h100, 32'h0, 4'hF));
    exp_q.push_back(rsp_e(1'b0, 1'b0, 32'hDEAD_BEEF));
    set_req(0, 1'b0, 32'h100, 32'h0, 4'h3);
    man_accept = 1;
    @(negedge clk);
    check("t1_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
    cyc();
    bus.req0_valid = 0;
    @(negedge clk);
    check("t1_mcmd_rd", bus.MCmd, 3'd2);
    check("t1_maddr", bus.MAddr, 32'h100);
    check("t1_be_all", bus.MByteEn, 4'hF);
    check("t1_st_cmd", fsm_state, ST_CMD);
    cyc();
    man_accept = 0; man_resp = 2'd1; man_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_mcmd_idle", bus.MCmd, 3'd0);
    check("t1_st_resp", fsm_state, ST_RESP);
    check("t1_no_early", bus.rsp0_valid, 1'b0);
    cyc();
    man_resp = 0; man_data = '0;
    @(negedge clk);
    check("t1_rsp", {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata}, {2'b10, 32'hDEAD_BEEF});
    check("t1_st_idle", fsm_state, ST_IDLE);
    cyc();
    @(negedge clk);
    check("t1_pulse", bus.rsp0_valid, 1'b0);
    drain("t1_drain");

    // Test 2: two writes at once, port 0 first after reset.
    do_reset();
    auto_en = 1;
    cmd_q.push_back(cmd_e(3'd1, 32'h10, 32'h1111_1111, 4'hF));
    cmd_q.push_back(cmd_e(3'd1, 32'h20, 32'h2222_2222, 4'h3));
    exp_q.push_back(rsp_e(1'b0, 1'b0, 32'h0));
    exp_q.push_back(rsp_e(1'b1, 1'b0, 32'h0));
    fork
      issue(0, 1'b1, 32'h10, 32'h1111_1111, 4'hF);
      issue(1, 1'b1, 32'h20, 32'h2222_2222, 4'h3);
    join
    drain("t2_drain");

    // Test 3: both held valid, grants alternate over 8 transactions.
    do_reset();
    auto_en = 1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        cmd_q.push_back(cmd_e(3'd2, 32'h200, 32'h0, 4'hF));
        exp_q.push_back(rsp_e(1'b0, 1'b0, 32'hA5A5_0200));
      end else begin
        cmd_q.push_back(cmd_e(3'd2, 32'h300, 32'h0, 4'hF));
        exp_q.push_back(rsp_e(1'b1, 1'b0, 32'hA5A5_0300));
      end
    end
    set_req(0, 1'b0, 32'h200, 32'h0, 4'h1);
    set_req(1, 1'b0, 32'h300, 32'h0, 4'hF);
    hs = 0;
    for (int i = 0; i < 120 && hs < 8; i++) begin
      @(negedge clk);
      hs = hs + int'(bus.req0_ready) + int'(bus.req1_ready);
    end
    cyc();
    clear_reqs();
    check("t3_handshakes", hs, 8);
    drain("t3_drain");

    // Test 4: SCmdAccept low for 5 cycles, stray ERR ignored in CMD.
    do_reset();
    cmd_q.push_back(cmd_e(3'd2, 32'h400, 32'h0, 4'hF));
    exp_q.push_back(rsp_e(1'b1, 1'b0, 32'hCAFE_F00D));
    set_req(1, 1'b0, 32'h400, 32'h0, 4'hF);
    @(negedge clk);
    check("t4_ready", {bus.req1_ready, bus.req0_ready}, 2'b10);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) bus.req1_valid = 0;
      if (c == 3) man_resp = 2'd3;
      if (c == 4) man_resp = 2'd0;
      if (c == 6) man_accept = 1;
      @(negedge clk);
      check("t4_hold", {bus.MCmd, bus.MAddr}, {3'd2, 32'h400});
    end
    cyc();
    man_accept = 0; man_resp = 2'd1; man_data = 32'hCAFE_F00D;
    @(negedge clk);
    check("t4_mcmd_idle", bus.MCmd, 3'd0);
    cyc();
    man_resp = 0; man_data = '0;
    @(negedge clk);
    check("t4_rsp", {bus.rsp1_valid, bus.rsp1_err}, 2'b10);
    drain("t4_drain");

    // Test 5: no response, timeout at count 7, late DVA ignored.
    do_reset();
    cmd_q.push_back(cmd_e(3'd2, 32'h500, 32'h0, 4'hF));
    exp_q.push_back(rsp_e(1'b0, 1'b1, 32'h0));
    set_req(0, 1'b0, 32'h500, 32'h0, 4'hF);
    man_accept = 1;
    @(negedge clk);
    check("t5_ready", bus.req0_ready, 1'b1);
    cyc();
    bus.req0_valid = 0;
    for (int c = 2; c <= 8; c++) begin
      cyc();
      if (c == 2) man_accept = 0;
      @(negedge clk);
      check("t5_quiet", bus.rsp0_valid, 1'b0);
    end
    cyc();
    man_resp = 2'd1; man_data = 32'h7777_7777;
    @(negedge clk);
    check("t5_tmo_rsp", {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata}, {2'b11, 32'h0});
    check("t5_st_idle", fsm_state, ST_IDLE);
    cyc();
    man_resp = 0; man_data = '0;
    @(negedge clk);
    check("t5_late_ign", bus.rsp0_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("t5_late_ign2", {bus.rsp0_valid, fsm_state}, {1'b0, ST_IDLE});
    drain("t5_drain");

    // Test 6: reset during RESP clears everything; port 0 wins afterwards.
    do_reset();
    auto_en = 1;
    cmd_q.push_back(cmd_e(3'd2, 32'h700, 32'h0, 4'hF));
    exp_q.push_back(rsp_e(1'b0, 1'b0, 32'hA5A5_0700));
    issue(0, 1'b0, 32'h700, 32'h0, 4'hF);
    drain("t6_pre_drain");
    auto_resp_en = 0;
    cmd_q.push_back(cmd_e(3'd2, 32'h800, 32'h0, 4'hF));
    issue(1, 1'b0, 32'h800, 32'h0, 4'hF);
    cyc();
    @(negedge clk);
    check("t6_st_resp", fsm_state, ST_RESP);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_st", fsm_state, ST_IDLE);
    check("t6_async_ocp", {bus.MCmd, bus.MAddr, bus.MData, bus.MByteEn}, 0);
    check("t6_async_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp0_rdata}, 0);
    check("t6_async_rdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
    repeat (2) cyc();
    rst_n = 1'b1;
    auto_resp_en = 1;
    cmd_q.push_back(cmd_e(3'd2, 32'h900, 32'h0, 4'hF));
    cmd_q.push_back(cmd_e(3'd2, 32'hA00, 32'h0, 4'hF));
    exp_q.push_back(rsp_e(1'b0, 1'b0, 32'hA5A5_0900));
    exp_q.push_back(rsp_e(1'b1, 1'b0, 32'hA5A5_0A00));
    fork
      issue(0, 1'b0, 32'h900, 32'h0, 4'hF);
      issue(1, 1'b0, 32'hA00, 32'h0, 4'hF);
    join
    drain("t6_drain");

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
